// File: rtl/four_channel_tdm_demux.sv
// Four-channel serial TDM demultiplexer.
// Deserialises a framed 1-bit stream into four parallel channel words.
module four_channel_tdm_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch_a,
  output logic [WIDTH-1:0] ch_b,
  output logic [WIDTH-1:0] ch_c,
  output logic [WIDTH-1:0] ch_d,
  output logic             out_valid,
  output logic             sync_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    HUNT,
    RUN
  } state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [1:0]       slot;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] stg_a;
  logic [WIDTH-1:0] stg_b;
  logic [WIDTH-1:0] stg_c;

  logic [WIDTH-1:0] word;
  logic             at_start;
  logic             at_last;
  logic             early;
  logic             missing;
  logic             advance;

  // Current word candidate and framing position flags.
  always_comb begin
    word     = {shreg, din};
    at_start = (bit_cnt == '0) && (slot == 2'd0);
    at_last  = (bit_cnt == CW'(WIDTH - 1));
    early    = frame_sync && !at_start;
    missing  = !frame_sync && at_start;
    advance  = !early && !missing;
  end

  // Framing FSM, deserialiser and registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      slot      <= 2'd0;
      shreg     <= '0;
      stg_a     <= '0;
      stg_b     <= '0;
      stg_c     <= '0;
      ch_a      <= '0;
      ch_b      <= '0;
      ch_c      <= '0;
      ch_d      <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (en) begin
        unique case (state)
          HUNT: begin
            if (frame_sync) begin
              state   <= RUN;
              shreg   <= word[WIDTH-2:0];
              bit_cnt <= CW'(1);
              slot    <= 2'd0;
            end
          end
          RUN: begin
            unique case (1'b1)
              early: begin
                sync_err <= 1'b1;
                shreg    <= word[WIDTH-2:0];
                bit_cnt  <= CW'(1);
                slot     <= 2'd0;
              end
              missing: begin
                sync_err <= 1'b1;
                state    <= HUNT;
                bit_cnt  <= '0;
                slot     <= 2'd0;
              end
              advance: begin
                shreg <= word[WIDTH-2:0];
                if (at_last) begin
                  bit_cnt <= '0;
                  slot    <= slot + 2'd1;
                  unique case (slot)
                    2'd0: stg_a <= word;
                    2'd1: stg_b <= word;
                    2'd2: stg_c <= word;
                    2'd3: begin
                      ch_a      <= stg_a;
                      ch_b      <= stg_b;
                      ch_c      <= stg_c;
                      ch_d      <= word;
                      out_valid <= 1'b1;
                    end
                  endcase
                end else begin
                  bit_cnt <= bit_cnt + CW'(1);
                end
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule
